// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small write FIFO in front of it.
// The frame is start bit, DATA_W data bits LSB first, an optional parity bit, then STOP_BITS stop bits.
module uart_tx_fifo #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [15:0]                     baud_div,
    input  logic [1:0]                      parity_mode,
    output logic                            tx,
    output logic                            busy,
    output logic                            full,
    output logic [$clog2(FIFO_DEPTH):0]     count,
    output logic                            overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned BW = $clog2(DATA_W);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [15:0]         baud_cnt;
    logic [15:0]         div_q;
    logic [BW-1:0]       bit_idx;
    logic                stop_cnt;
    logic [DATA_W-1:0]   shifter;
    logic                par_en_q;
    logic                par_bit_q;

    logic                push_c;
    logic                pop_c;
    logic                bit_end_c;
    logic                stop_last_c;
    logic [CW-1:0]       count_nxt_c;
    logic [DATA_W-1:0]   head_c;

    // A pop happens when idle with data, or on the last clock of the final stop bit.
    always_comb begin
        push_c      = wr_en && !full;
        bit_end_c   = (baud_cnt == div_q);
        stop_last_c = (state == STOP) && bit_end_c && (stop_cnt == 1'(STOP_BITS - 1));
        pop_c       = (count != '0) && ((state == IDLE) || stop_last_c);
        count_nxt_c = count + CW'(push_c) - CW'(pop_c);
        head_c      = mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (rst_n && push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            tx        <= 1'b1;
            busy      <= 1'b0;
            count     <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            baud_cnt  <= '0;
            div_q     <= '0;
            bit_idx   <= '0;
            stop_cnt  <= 1'b0;
            shifter   <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            count <= count_nxt_c;
            full  <= (count_nxt_c == CW'(FIFO_DEPTH));
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (push_c) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (state != IDLE) begin
                baud_cnt <= bit_end_c ? 16'd0 : baud_cnt + 16'd1;
            end

            // Frame start: bit timing and parity are frozen here for the whole frame.
            if (pop_c) begin
                state     <= START;
                tx        <= 1'b0;
                busy      <= 1'b1;
                baud_cnt  <= '0;
                div_q     <= baud_div;
                shifter   <= head_c;
                par_en_q  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
                par_bit_q <= (^head_c) ^ (parity_mode == 2'b10);
            end else begin
                case (state)
                    IDLE: begin
                        tx   <= 1'b1;
                        busy <= 1'b0;
                    end
                    START: begin
                        if (bit_end_c) begin
                            state   <= DATA;
                            tx      <= shifter[0];
                            shifter <= shifter >> 1;
                            bit_idx <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_end_c) begin
                            if (bit_idx == BW'(DATA_W - 1)) begin
                                if (par_en_q) begin
                                    state <= PARITY;
                                    tx    <= par_bit_q;
                                end else begin
                                    state    <= STOP;
                                    tx       <= 1'b1;
                                    stop_cnt <= 1'b0;
                                end
                            end else begin
                                bit_idx <= bit_idx + BW'(1);
                                tx      <= shifter[0];
                                shifter <= shifter >> 1;
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end_c) begin
                            state    <= STOP;
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                        end
                    end
                    STOP: begin
                        if (bit_end_c) begin
                            if (stop_cnt == 1'(STOP_BITS - 1)) begin
                                state <= IDLE;
                                tx    <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: frame shapes, parity, FIFO limits, back-to-back frames and reset abort.
// A second instance with two stop bits covers the two-stop-bit frame.
module tb_uart_tx_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic        wr_en2;
    logic [7:0]  wr_data;
    logic [15:0] baud_div;
    logic [1:0]  parity_mode;

    logic        tx, busy, full, overflow;
    logic [2:0]  count;
    logic        tx2, busy2, full2, overflow2;
    logic [2:0]  count2;

    int tests_run = 0;
    int tests_failed = 0;

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(1)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
        .baud_div(baud_div), .parity_mode(parity_mode),
        .tx(tx), .busy(busy), .full(full), .count(count), .overflow(overflow)
    );

    uart_tx_fifo #(.DATA_W(8), .FIFO_DEPTH(4), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en2), .wr_data(wr_data),
        .baud_div(baud_div), .parity_mode(parity_mode),
        .tx(tx2), .busy(busy2), .full(full2), .count(count2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_and_start(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        tick();
        wr_en   = 1'b0;
        tick();
    endtask

    // bits holds the expected line value per bit period, bit 0 sent first.
    task automatic check_frame(input string tag, input logic [31:0] bits, input int n,
                               input int bp, input bit sel);
        for (int b = 0; b < n; b++) begin
            for (int k = 0; k < bp; k++) begin
                check({tag, "_tx"}, 32'(sel ? tx2 : tx), 32'(bits[b]));
                check({tag, "_busy"}, 32'(sel ? busy2 : busy), 32'd1);
                tick();
            end
        end
        check({tag, "_idle_tx"}, 32'(sel ? tx2 : tx), 32'd1);
        check({tag, "_idle_busy"}, 32'(sel ? busy2 : busy), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int exp_count [6] = '{1, 1, 2, 3, 4, 4};
        int exp_full  [6] = '{0, 0, 0, 0, 1, 1};
        int exp_ovf   [6] = '{0, 0, 0, 0, 0, 1};
        int exp_busy  [6] = '{0, 1, 1, 1, 1, 1};
        bit disturbed;

        rst_n = 1'b0; wr_en = 1'b0; wr_en2 = 1'b0; wr_data = '0;
        baud_div = 16'd3; parity_mode = 2'b00;
        do_reset();
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst2_count", 32'(count2), 32'd0);

        // First write into an empty FIFO: tx still high one edge later, falls the edge after.
        wr_data = 8'hA5; wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        check("a5_count1", 32'(count), 32'd1);
        check("a5_pre_tx", 32'(tx), 32'd1);
        tick();
        check("a5_popped", 32'(count), 32'd0);
        check_frame("a5", 32'({1'b1, 8'hA5, 1'b0}), 10, 4, 1'b0);

        // Even parity; settings changed mid-frame must not affect this frame.
        parity_mode = 2'b01;
        push_and_start(8'h07);
        baud_div = 16'd0; parity_mode = 2'b00;
        check_frame("even07", 32'({1'b1, 1'b1, 8'h07, 1'b0}), 11, 4, 1'b0);

        baud_div = 16'd3; parity_mode = 2'b10;
        push_and_start(8'h07);
        check_frame("odd07", 32'({1'b1, 1'b0, 8'h07, 1'b0}), 11, 4, 1'b0);

        // Back-to-back frames: no idle clocks between stop and next start.
        parity_mode = 2'b00;
        wr_data = 8'h55; wr_en = 1'b1;
        tick();
        wr_data = 8'h0F;
        tick();
        wr_en = 1'b0;
        check_frame("b2b", 32'({1'b1, 8'h0F, 1'b0, 1'b1, 8'h55, 1'b0}), 20, 4, 1'b0);

        // Six consecutive writes into a 4-deep FIFO with a slow line.
        baud_div = 16'd100;
        for (int i = 0; i < 6; i++) begin
            wr_data = 8'(i + 1); wr_en = 1'b1;
            tick();
            check($sformatf("ovf_count%0d", i), 32'(count), 32'(exp_count[i]));
            check($sformatf("ovf_full%0d", i), 32'(full), 32'(exp_full[i]));
            check($sformatf("ovf_flag%0d", i), 32'(overflow), 32'(exp_ovf[i]));
            check($sformatf("ovf_busy%0d", i), 32'(busy), 32'(exp_busy[i]));
        end
        wr_en = 1'b0;
        repeat (5) tick();
        check("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        check("ovf_cleared", 32'(overflow), 32'd0);

        // Reset mid-DATA with two entries queued aborts everything.
        baud_div = 16'd3;
        wr_en = 1'b1;
        wr_data = 8'h11; tick();
        wr_data = 8'h22; tick();
        wr_data = 8'h33; tick();
        wr_en = 1'b0;
        check("abort_queued", 32'(count), 32'd2);
        repeat (5) tick();
        check("abort_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0; wr_en = 1'b1;
        tick();
        rst_n = 1'b1; wr_en = 1'b0;
        check("abort_tx", 32'(tx), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_count", 32'(count), 32'd0);
        check("abort_full", 32'(full), 32'd0);
        disturbed = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) disturbed = 1'b1;
        end
        check("abort_quiet", 32'(disturbed), 32'd0);

        // Two stop bits at one clock per bit.
        baud_div = 16'd0;
        wr_data = 8'h00; wr_en2 = 1'b1;
        tick();
        wr_en2 = 1'b0;
        tick();
        check_frame("stop2", 32'({2'b11, 8'h00, 1'b0}), 11, 1, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
